// File: rtl/mc_control_ext.sv
// Multicycle main control FSM for the MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback with memory-ready wait states.
module mc_control_ext #(
   parameter int EXT_OPS   = 1,
   parameter int USE_READY = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       mem_write,
   output logic       mem_read,
   output logic       ir_write,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic       branch,
   output logic       nef,
   output logic       iord,
   output logic [1:0] mem_to_reg,
   output logic [1:0] reg_dst,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_src,
   output logic [2:0] alu_op,
   output logic       illegal_op,
   output logic [4:0] state_out
);

   localparam logic [4:0] FETCH  = 5'd0;
   localparam logic [4:0] DECODE = 5'd1;
   localparam logic [4:0] MEMADR = 5'd2;
   localparam logic [4:0] MEMRD  = 5'd3;
   localparam logic [4:0] MEMWB  = 5'd4;
   localparam logic [4:0] MEMWR  = 5'd5;
   localparam logic [4:0] EXEC   = 5'd6;
   localparam logic [4:0] ALUWB  = 5'd7;
   localparam logic [4:0] BEQ    = 5'd8;
   localparam logic [4:0] ADDIEX = 5'd9;
   localparam logic [4:0] IWB    = 5'd10;
   localparam logic [4:0] JUMP   = 5'd11;
   localparam logic [4:0] BNE    = 5'd12;
   localparam logic [4:0] ANDIEX = 5'd13;
   localparam logic [4:0] ORIEX  = 5'd14;
   localparam logic [4:0] SLTIEX = 5'd15;
   localparam logic [4:0] JAL    = 5'd16;

   localparam logic EXT = (EXT_OPS != 0);

   logic [4:0] state, next_state, dec_state;
   logic       dec_legal;
   logic       ready;

   // With the handshake disabled, every memory access completes immediately.
   assign ready = (USE_READY != 0) ? mem_ready : 1'b1;

   always_comb begin
      dec_state = FETCH;
      dec_legal = 1'b1;
      case (op)
         6'h00:        dec_state = EXEC;
         6'h23, 6'h2B: dec_state = MEMADR;
         6'h04:        dec_state = BEQ;
         6'h05:        dec_state = BNE;
         6'h08:        dec_state = ADDIEX;
         6'h02:        dec_state = JUMP;
         6'h0C:        begin dec_state = EXT ? ANDIEX : FETCH; dec_legal = EXT; end
         6'h0D:        begin dec_state = EXT ? ORIEX  : FETCH; dec_legal = EXT; end
         6'h0A:        begin dec_state = EXT ? SLTIEX : FETCH; dec_legal = EXT; end
         6'h03:        begin dec_state = EXT ? JAL    : FETCH; dec_legal = EXT; end
         default:      dec_legal = 1'b0;
      endcase
   end

   always_comb begin
      next_state = FETCH;
      case (state)
         FETCH:  next_state = ready ? DECODE : FETCH;
         DECODE: next_state = dec_state;
         MEMADR: next_state = (op == 6'h23) ? MEMRD : MEMWR;
         MEMRD:  next_state = ready ? MEMWB : MEMRD;
         MEMWR:  next_state = ready ? FETCH : MEMWR;
         EXEC:   next_state = ALUWB;
         ADDIEX, ANDIEX, ORIEX, SLTIEX: next_state = IWB;
         default: next_state = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= FETCH;
      else       state <= next_state;
   end

   always_comb begin
      pc_write   = 1'b0;
      mem_write  = 1'b0;
      mem_read   = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      branch     = 1'b0;
      nef        = 1'b0;
      iord       = 1'b0;
      mem_to_reg = 2'b00;
      reg_dst    = 2'b00;
      alu_src_b  = 2'b00;
      pc_src     = 2'b00;
      alu_op     = 3'b000;
      case (state)
         FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = ready;
            pc_write  = ready;
         end
         DECODE: alu_src_b = 2'b11;
         MEMADR: begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
         MEMRD:  begin mem_read = 1'b1; iord = 1'b1; end
         MEMWB:  begin reg_write = 1'b1; mem_to_reg = 2'b01; end
         MEMWR:  begin mem_write = 1'b1; iord = 1'b1; end
         EXEC:   begin alu_src_a = 1'b1; alu_op = 3'b010; end
         ALUWB:  begin reg_write = 1'b1; reg_dst = 2'b01; end
         BEQ, BNE: begin
            alu_src_a = 1'b1;
            branch    = 1'b1;
            pc_src    = 2'b01;
            alu_op    = 3'b001;
            nef       = (state == BNE);
         end
         ADDIEX, ANDIEX, ORIEX, SLTIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            case (state)
               ANDIEX:  alu_op = 3'b011;
               ORIEX:   alu_op = 3'b100;
               SLTIEX:  alu_op = 3'b101;
               default: alu_op = 3'b000;
            endcase
         end
         IWB:  reg_write = 1'b1;
         JUMP: begin pc_write = 1'b1; pc_src = 2'b10; end
         JAL: begin
            pc_write   = 1'b1;
            pc_src     = 2'b10;
            reg_write  = 1'b1;
            reg_dst    = 2'b10;
            mem_to_reg = 2'b10;
         end
         default: ;
      endcase
   end

   assign illegal_op = (state == DECODE) && !dec_legal;
   assign state_out  = state;

endmodule

// File: tb/tb_mc_control_ext.sv
// Scoreboard bench for mc_control_ext: per-instruction phase model pushes expected
// per-cycle outputs; monitors on the falling edge pop and compare.
module tb_mc_control_ext;

   typedef struct packed {
      logic [4:0] st;
      logic pcw, mw, mr, irw, rw, asa, br, nef, iord;
      logic [1:0] m2r, rdst, asb, psrc;
      logic [2:0] aop;
      logic ill;
   } exp_t;

   localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMRD = 3, P_MEMWB = 4,
                  P_MEMWR = 5, P_EXEC = 6, P_ALUWB = 7, P_BEQ = 8, P_ADDIEX = 9,
                  P_IWB = 10, P_JUMP = 11, P_BNE = 12, P_ANDIEX = 13, P_ORIEX = 14,
                  P_SLTIEX = 15, P_JAL = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic [5:0] op_a = 6'h00, op_b = 6'h00;
   logic       rdy_a = 1'b1, rdy_b = 1'b1;
   exp_t       act_a, act_b, ea, eb;
   exp_t       qa[$], qb[$];
   int         compared = 0, mismatched = 0;

   // Instance a: full feature set with handshake; instance b: base ops, handshake ignored.
   mc_control_ext #(.EXT_OPS(1), .USE_READY(1)) u_dut_a (
      .clk(clk), .reset(reset), .op(op_a), .mem_ready(rdy_a),
      .pc_write(act_a.pcw), .mem_write(act_a.mw), .mem_read(act_a.mr), .ir_write(act_a.irw),
      .reg_write(act_a.rw), .alu_src_a(act_a.asa), .branch(act_a.br), .nef(act_a.nef),
      .iord(act_a.iord), .mem_to_reg(act_a.m2r), .reg_dst(act_a.rdst), .alu_src_b(act_a.asb),
      .pc_src(act_a.psrc), .alu_op(act_a.aop), .illegal_op(act_a.ill), .state_out(act_a.st));

   mc_control_ext #(.EXT_OPS(0), .USE_READY(0)) u_dut_b (
      .clk(clk), .reset(reset), .op(op_b), .mem_ready(rdy_b),
      .pc_write(act_b.pcw), .mem_write(act_b.mw), .mem_read(act_b.mr), .ir_write(act_b.irw),
      .reg_write(act_b.rw), .alu_src_a(act_b.asa), .branch(act_b.br), .nef(act_b.nef),
      .iord(act_b.iord), .mem_to_reg(act_b.m2r), .reg_dst(act_b.rdst), .alu_src_b(act_b.asb),
      .pc_src(act_b.psrc), .alu_op(act_b.aop), .illegal_op(act_b.ill), .state_out(act_b.st));

   // Output table for each state of the controller.
   function automatic exp_t exp_of(input int st, input logic rdy, input logic ill);
      exp_t e = '0;
      e.st = 5'(st);
      case (st)
         P_FETCH:  begin e.mr = 1; e.asb = 2'b01; e.irw = rdy; e.pcw = rdy; end
         P_DECODE: begin e.asb = 2'b11; e.ill = ill; end
         P_MEMADR: begin e.asa = 1; e.asb = 2'b10; end
         P_MEMRD:  begin e.mr = 1; e.iord = 1; end
         P_MEMWB:  begin e.rw = 1; e.m2r = 2'b01; end
         P_MEMWR:  begin e.mw = 1; e.iord = 1; end
         P_EXEC:   begin e.asa = 1; e.aop = 3'b010; end
         P_ALUWB:  begin e.rw = 1; e.rdst = 2'b01; end
         P_BEQ:    begin e.asa = 1; e.br = 1; e.psrc = 2'b01; e.aop = 3'b001; end
         P_BNE:    begin e.asa = 1; e.br = 1; e.psrc = 2'b01; e.aop = 3'b001; e.nef = 1; end
         P_ADDIEX: begin e.asa = 1; e.asb = 2'b10; e.aop = 3'b000; end
         P_ANDIEX: begin e.asa = 1; e.asb = 2'b10; e.aop = 3'b011; end
         P_ORIEX:  begin e.asa = 1; e.asb = 2'b10; e.aop = 3'b100; end
         P_SLTIEX: begin e.asa = 1; e.asb = 2'b10; e.aop = 3'b101; end
         P_IWB:    e.rw = 1;
         P_JUMP:   begin e.pcw = 1; e.psrc = 2'b10; end
         P_JAL:    begin e.pcw = 1; e.psrc = 2'b10; e.rw = 1; e.rdst = 2'b10; e.m2r = 2'b10; end
         default:  ;
      endcase
      return e;
   endfunction

   // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
   task automatic step(input int d, input logic [5:0] o, input logic r, input int st,
                       input logic rexp, input logic ill);
      if (d == 0) begin op_a = o; rdy_a = r; qa.push_back(exp_of(st, rexp, ill)); end
      else        begin op_b = o; rdy_b = r; qb.push_back(exp_of(st, rexp, ill)); end
      @(posedge clk); #1;
   endtask

   // fw / mw: wait cycles in FETCH and in the memory state, -1 = random.
   task automatic run_instr(input int d, input logic [5:0] o, input int fw, input int mw);
      int   ph[$];
      logic ext = (d == 0);
      logic use_rdy = (d == 0);
      logic legal = 1'b1;
      int   w;
      case (o)
         6'h23: ph = '{P_MEMADR, P_MEMRD, P_MEMWB};
         6'h2B: ph = '{P_MEMADR, P_MEMWR};
         6'h00: ph = '{P_EXEC, P_ALUWB};
         6'h04: ph = '{P_BEQ};
         6'h05: ph = '{P_BNE};
         6'h08: ph = '{P_ADDIEX, P_IWB};
         6'h02: ph = '{P_JUMP};
         6'h0C: if (ext) ph = '{P_ANDIEX, P_IWB}; else legal = 1'b0;
         6'h0D: if (ext) ph = '{P_ORIEX, P_IWB};  else legal = 1'b0;
         6'h0A: if (ext) ph = '{P_SLTIEX, P_IWB}; else legal = 1'b0;
         6'h03: if (ext) ph = '{P_JAL};           else legal = 1'b0;
         default: legal = 1'b0;
      endcase
      ph.push_front(P_DECODE);
      ph.push_front(P_FETCH);
      foreach (ph[i]) begin
         if (ph[i] == P_FETCH || ph[i] == P_MEMRD || ph[i] == P_MEMWR) begin
            w = (ph[i] == P_FETCH) ? fw : mw;
            if (w < 0) w = $urandom_range(0, 3);
            if (use_rdy) begin
               repeat (w) step(d, o, 1'b0, ph[i], 1'b0, 1'b0);
               step(d, o, 1'b1, ph[i], 1'b1, 1'b0);
            end else begin
               step(d, o, 1'($urandom_range(0, 1)), ph[i], 1'b1, 1'b0);
            end
         end else begin
            step(d, o, 1'($urandom_range(0, 1)), ph[i], 1'b1, (ph[i] == P_DECODE) && !legal);
         end
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   function automatic logic [5:0] rand_op();
      logic [5:0] ops [11] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08,
                               6'h02, 6'h0C, 6'h0D, 6'h0A, 6'h03};
      if ($urandom_range(0, 9) == 0) return 6'($urandom_range(0, 63));
      return ops[$urandom_range(0, 10)];
   endfunction

   always @(negedge clk) begin
      if (qa.size() > 0) begin
         ea = qa.pop_front();
         compared++;
         if (act_a !== ea) begin
            mismatched++;
            $display("FAIL dut_a state_outputs: got %h expected %h (st got %0d exp %0d) t=%0t",
                     act_a, ea, act_a.st, ea.st, $time);
         end
      end
   end

   always @(negedge clk) begin
      if (qb.size() > 0) begin
         eb = qb.pop_front();
         compared++;
         if (act_b !== eb) begin
            mismatched++;
            $display("FAIL dut_b state_outputs: got %h expected %h (st got %0d exp %0d) t=%0t",
                     act_b, eb, act_b.st, eb.st, $time);
         end
      end
   end

   task automatic drain();
      for (int i = 0; i < 8 && (qa.size() > 0 || qb.size() > 0); i++) @(negedge clk);
      if (qa.size() > 0 || qb.size() > 0) begin
         compared++;
         mismatched++;
         $display("FAIL drain: %0d/%0d entries left, expected 0", qa.size(), qb.size());
      end
      @(posedge clk); #1;
   endtask

   initial begin
      do_reset();
      // Directed sequence on the full-featured instance.
      run_instr(0, 6'h23, 0, 0);
      run_instr(0, 6'h2B, 0, 3);
      run_instr(0, 6'h05, 0, 0);
      run_instr(0, 6'h03, 0, 0);
      run_instr(0, 6'h0D, 0, 0);
      run_instr(0, 6'h0A, 0, 0);
      run_instr(0, 6'h23, 2, 2);
      // Reset held for two edges while stalled in MEMWR.
      step(0, 6'h2B, 1'b1, P_FETCH, 1'b1, 1'b0);
      step(0, 6'h2B, 1'b1, P_DECODE, 1'b1, 1'b0);
      step(0, 6'h2B, 1'b1, P_MEMADR, 1'b1, 1'b0);
      step(0, 6'h2B, 1'b0, P_MEMWR, 1'b0, 1'b0);
      reset = 1'b1;
      step(0, 6'h2B, 1'b0, P_MEMWR, 1'b0, 1'b0);
      step(0, 6'h2B, 1'b0, P_FETCH, 1'b0, 1'b0);
      reset = 1'b0;
      for (int i = 0; i < 300; i++) run_instr(0, rand_op(), -1, -1);
      drain();

      // Base-op instance with the handshake ignored.
      do_reset();
      run_instr(1, 6'h03, 0, 0);
      run_instr(1, 6'h2B, 0, 0);
      run_instr(1, 6'h0D, 0, 0);
      for (int i = 0; i < 150; i++) run_instr(1, rand_op(), -1, -1);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
